hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_if.sv | 38 +++
 rtl/hazard_controller.sv | 112 +++++++++++
 tb/tb_hazard_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: ID/EX hazard inputs plus pipeline enable/flush outputs.
// Purely combinational wiring; no latency of its own.
// No flow control: the controller drives enables every cycle, the pipeline obeys.
interface hazard_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic [6:0]           id_opcode;
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 ex_mem_read;
  logic [4:0]           ex_rd;
  logic                 ex_branch_taken;
  logic                 mem_wait;
  logic                 pc_write;
  logic                 if_id_write;
  logic                 id_ex_write;
  logic                 ex_mem_write;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;
  logic [1:0]           state;
  logic                 timeout_err;

  // Pipeline side: presents hazard information, consumes enables and status.
  modport master (
    output id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_taken, mem_wait,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
    input  stall_count, flush_count, state, timeout_err
  );

  // Controller side.
  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_taken, mem_wait,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
    output stall_count, flush_count, state, timeout_err
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze/timeout.
// Enables/flushes are combinational from state and inputs; state/counters update on clk.
// mem_wait freezes every pipeline register; a stuck memory halts the pipe until reset.
module hazard_controller #(
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;

  // Wait counter value on the last permitted MEM_WAIT cycle.
  localparam logic [7:0]           WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               state_q;
  logic [7:0]           wait_cnt;
  logic                 br_pending;
  logic                 timeout_q;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  logic use_rs1;
  logic use_rs2;
  logic load_use;
  logic branch;
  logic resolve;
  logic take_branch;
  logic take_stall;

  // Decode register usage of the ID instruction and resolve this cycle's hazard.
  always_comb begin
    use_rs2 = (hz.id_opcode == OP_R) || (hz.id_opcode == OP_S) || (hz.id_opcode == OP_B);
    use_rs1 = use_rs2 || (hz.id_opcode == OP_I) || (hz.id_opcode == OP_L);
    load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                (use_rs2 && (hz.ex_rd == hz.id_rs2)));
    // A branch that resolved while frozen is replayed on the exit cycle.
    branch = hz.ex_branch_taken || ((state_q == MEM_WAIT) && br_pending);
    // The pipe only advances when memory is ready and we are not halted.
    resolve     = !rst && !hz.mem_wait && (state_q != HALT);
    take_branch = resolve && branch;
    take_stall  = resolve && !branch && load_use;
  end

  // Drive enables and flushes; branch beats load-use, freeze beats both.
  always_comb begin
    hz.pc_write     = resolve && !take_stall;
    hz.if_id_write  = resolve && !take_stall;
    hz.id_ex_write  = resolve;
    hz.ex_mem_write = resolve;
    hz.if_id_flush  = take_branch;
    hz.id_ex_flush  = take_branch || take_stall;
  end

  assign hz.state       = state_q;
  assign hz.timeout_err = timeout_q;
  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;

  // State machine, wait timer, pending branch and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt   <= '0;
      br_pending <= 1'b0;
      timeout_q  <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (take_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (take_branch && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
      case (state_q)
        RUN: begin
          if (hz.mem_wait) begin
            state_q  <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (hz.mem_wait) begin
            if (hz.ex_branch_taken) br_pending <= 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              state_q   <= HALT;
              timeout_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end else begin
            br_pending <= 1'b0;
            state_q    <= RUN;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus a randomized run against a
// cycle-level reference model. Small counters and short timeout make saturation
// and halt reachable in few cycles.
module tb_hazard_controller;
  localparam int CW   = 2;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_WIDTH(CW)) hz ();
  hazard_controller #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .hz(hz));

  int tests = 0;
  int fails = 0;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush}
  logic [5:0] outs;
  assign outs = {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
                 hz.if_id_flush, hz.id_ex_flush};

  // Reference model state (0=RUN, 1=MEM_WAIT, 2=HALT)
  int m_state, m_wait, m_stall, m_flush;
  bit m_brp, m_terr;
  int n_state, n_wait, n_stall, n_flush;
  bit n_brp, n_terr;
  logic [5:0] exp_outs;

  task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic mr, input logic [4:0] rd, input logic br, input logic mw);
    hz.id_opcode = op; hz.id_rs1 = r1; hz.id_rs2 = r2;
    hz.ex_mem_read = mr; hz.ex_rd = rd; hz.ex_branch_taken = br; hz.mem_wait = mw;
  endtask

  task automatic idle();
    drive(7'b0000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_brp = 0; m_terr = 0;
  endtask

  // One cycle of the rules: decide outputs and the state after the next edge.
  task automatic model_eval();
    bit u1, u2, lu, br_eff, res;
    u2 = (hz.id_opcode == 7'b0110011) || (hz.id_opcode == 7'b0100011) ||
         (hz.id_opcode == 7'b1100011);
    u1 = u2 || (hz.id_opcode == 7'b0010011) || (hz.id_opcode == 7'b0000011);
    lu = hz.ex_mem_read && (hz.ex_rd != 0) &&
         ((u1 && hz.ex_rd == hz.id_rs1) || (u2 && hz.ex_rd == hz.id_rs2));
    exp_outs = 6'b000000;
    n_state = m_state; n_wait = m_wait; n_stall = m_stall; n_flush = m_flush;
    n_brp = m_brp; n_terr = m_terr;
    res = 0; br_eff = hz.ex_branch_taken;
    if (m_state == 0) begin
      if (hz.mem_wait) begin n_state = 1; n_wait = 0; end
      else res = 1;
    end else if (m_state == 1) begin
      if (hz.mem_wait) begin
        if (hz.ex_branch_taken) n_brp = 1;
        if (m_wait == TO - 1) begin n_state = 2; n_terr = 1; end
        else n_wait = m_wait + 1;
      end else begin
        res = 1; br_eff = hz.ex_branch_taken || m_brp; n_brp = 0; n_state = 0;
      end
    end
    if (res) begin
      if (br_eff) begin
        exp_outs = 6'b111111;
        n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      end else if (lu) begin
        exp_outs = 6'b001101;
        n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end else begin
        exp_outs = 6'b111100;
      end
    end
  endtask

  task automatic model_commit();
    m_state = n_state; m_wait = n_wait; m_stall = n_stall; m_flush = n_flush;
    m_brp = n_brp; m_terr = n_terr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(7'b0110011, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    @(posedge clk); #1;
    tests++; if (outs !== 6'b000000) begin fails++; $display("FAIL reset_outs: got %b expected 000000", outs); end
    tests++; if (hz.state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b expected 00", hz.state); end
    tests++; if (hz.stall_count !== 2'd0 || hz.flush_count !== 2'd0) begin
      fails++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", hz.stall_count, hz.flush_count); end
    tests++; if (hz.timeout_err !== 1'b0) begin fails++; $display("FAIL reset_terr: got %b expected 0", hz.timeout_err); end
    @(negedge clk); rst = 1'b0; #1;
    tests++; if (outs !== 6'b111111) begin fails++; $display("FAIL reset_release_outs: got %b expected 111111", outs); end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(7'b0110011, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0); #1;
    tests++; if (outs !== 6'b001101) begin fails++; $display("FAIL load_use_outs: got %b expected 001101", outs); end
    @(posedge clk); @(negedge clk); idle(); #1;
    tests++; if (hz.stall_count !== 2'd1) begin fails++; $display("FAIL load_use_count: got %0d expected 1", hz.stall_count); end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive(7'b0010011, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0); #1;
    tests++; if (outs !== 6'b111100) begin fails++; $display("FAIL no_stall_rs2_unused: got %b expected 111100", outs); end
    @(posedge clk); @(negedge clk);
    drive(7'b0110011, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    tests++; if (outs !== 6'b111100) begin fails++; $display("FAIL no_stall_rd0: got %b expected 111100", outs); end
    @(posedge clk); @(negedge clk); idle(); #1;
    tests++; if (hz.stall_count !== 2'd0) begin fails++; $display("FAIL no_stall_count: got %0d expected 0", hz.stall_count); end
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    drive(7'b0110011, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0); #1;
    tests++; if (outs !== 6'b111111) begin fails++; $display("FAIL branch_wins_outs: got %b expected 111111", outs); end
    @(posedge clk); @(negedge clk); idle(); #1;
    tests++; if (hz.flush_count !== 2'd1 || hz.stall_count !== 2'd0) begin
      fails++; $display("FAIL branch_wins_counts: got flush %0d stall %0d expected 1/0", hz.flush_count, hz.stall_count); end
  endtask

  task automatic test_mem_wait_branch();
    logic [1:0] exp_st[5];
    logic [5:0] exp_o[5];
    exp_st = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    exp_o  = '{6'b000000, 6'b000000, 6'b000000, 6'b111111, 6'b111100};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      drive(7'b0000000, 5'd0, 5'd0, 1'b0, 5'd0, c == 2, c < 3); #1;
      tests++; if (hz.state !== exp_st[c] || outs !== exp_o[c]) begin
        fails++; $display("FAIL mem_wait_cycle%0d: got state %b outs %b expected %b %b",
                          c, hz.state, outs, exp_st[c], exp_o[c]); end
      @(posedge clk);
    end
    #1;
    tests++; if (hz.flush_count !== 2'd1) begin fails++; $display("FAIL mem_wait_flush_count: got %0d expected 1", hz.flush_count); end
  endtask

  task automatic test_timeout();
    logic [1:0] es;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 5) drive(7'b0000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      else       drive(7'b0110011, 5'd2, 5'd2, 1'b1, 5'd2, c == 5, 1'b0);
      #1;
      es = (c == 0) ? 2'b00 : (c <= 4) ? 2'b01 : 2'b10;
      tests++; if (hz.state !== es || hz.timeout_err !== (c >= 5) || outs !== 6'b000000) begin
        fails++; $display("FAIL timeout_cycle%0d: got state %b terr %b outs %b expected %b %b 000000",
                          c, hz.state, hz.timeout_err, outs, es, c >= 5); end
      @(posedge clk);
    end
    @(negedge clk); rst = 1'b1; #1;
    tests++; if (hz.state !== 2'b00 || hz.timeout_err !== 1'b0) begin
      fails++; $display("FAIL halt_reset: got state %b terr %b expected 00 0", hz.state, hz.timeout_err); end
    @(posedge clk); @(negedge clk); rst = 1'b0; idle(); #1;
    tests++; if (outs !== 6'b111100 || hz.state !== 2'b00) begin
      fails++; $display("FAIL halt_recover: got outs %b state %b expected 111100 00", outs, hz.state); end
  endtask

  task automatic test_saturation();
    int exp_cnt[5];
    exp_cnt = '{1, 2, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(7'b0000011, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
      @(posedge clk); #1;
      tests++; if (int'(hz.stall_count) !== exp_cnt[i]) begin
        fails++; $display("FAIL stall_sat_%0d: got %0d expected %0d", i, hz.stall_count, exp_cnt[i]); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_random();
    logic [6:0] ops[7];
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b0110111};
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0 || (m_state == 2 && $urandom_range(0, 7) == 0)) begin
        rst = 1'b1; #1;
        tests++; if (outs !== 6'b000000 || hz.state !== 2'b00 || hz.timeout_err !== 1'b0 ||
                     hz.stall_count !== 2'd0 || hz.flush_count !== 2'd0) begin
          fails++; $display("FAIL rand_reset cyc %0d: got outs %b state %b terr %b cnt %0d/%0d expected all zero",
                            cyc, outs, hz.state, hz.timeout_err, hz.stall_count, hz.flush_count); end
        model_reset();
        @(posedge clk); @(negedge clk); rst = 1'b0;
      end
      drive(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 2);
      #1;
      model_eval();
      tests++; if (outs !== exp_outs || int'(hz.state) !== m_state || int'(hz.stall_count) !== m_stall ||
                   int'(hz.flush_count) !== m_flush || hz.timeout_err !== m_terr) begin
        fails++; $display("FAIL rand cyc %0d: got outs %b st %0d stall %0d flush %0d terr %b expected %b %0d %0d %0d %b",
                          cyc, outs, hz.state, hz.stall_count, hz.flush_count, hz.timeout_err,
                          exp_outs, m_state, m_stall, m_flush, m_terr); end
      model_commit();
      @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_vs_load_use();
    test_mem_wait_branch();
    test_timeout();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
